// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the instruction loader/encoder.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,
        K_SUB  = 4'd1,
        K_AND  = 4'd2,
        K_OR   = 4'd3,
        K_XOR  = 4'd4,
        K_SLT  = 4'd5,
        K_ADDI = 4'd6,
        K_LB   = 4'd7,
        K_SB   = 4'd8,
        K_BEQ  = 4'd9
    } instr_kind_t;

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} loader_state_t;

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational field-to-word encoder for the RV32I subset the core decodes.
module instr_word_encoder
    import riscv_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Branch offsets are halfword aligned; bit 0 carries no information.
    logic unused_imm0;
    assign unused_imm0 = imm[0];

    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (kind)
            K_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_R};
            K_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OP_R};
            K_AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OP_R};
            K_OR:   word = {F7_BASE, rs2, rs1, F3_OR,  rd, OP_R};
            K_XOR:  word = {F7_BASE, rs2, rs1, F3_XOR, rd, OP_R};
            K_SLT:  word = {F7_BASE, rs2, rs1, F3_SLT, rd, OP_R};
            K_ADDI: word = {imm[11:0], rs1, F3_ADDI, rd, OP_I};
            K_LB:   word = {imm[11:0], rs1, F3_LB, rd, OP_LOAD};
            K_SB:   word = {imm[11:5], rs2, rs1, F3_SB, imm[4:0], OP_STORE};
            K_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                            imm[4:1], imm[11], OP_BRANCH};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader_encoder.sv
// Loads an encoded program into instruction memory from address 0, pads the
// tail with NOPs and holds the core until the image is complete.
module instr_loader_encoder
    import riscv_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    loader_state_t     state, state_n;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       enc_word, wdata_n;
    logic              enc_illegal;
    logic              accept, at_last, launch, we_n, err_set, done_set;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid & in_ready;
    assign at_last  = (wr_ptr == LAST_ADDR);

    instr_word_encoder u_enc (
        .kind    (in_kind),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        launch   = 1'b0;
        we_n     = 1'b0;
        wdata_n  = NOP_WORD;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                launch = start;
                if (start) state_n = LOAD;
            end
            LOAD: begin
                if (accept) begin
                    we_n    = 1'b1;
                    wdata_n = enc_word;
                    // Running out of memory before in_last means the program was cut short.
                    err_set = enc_illegal | (at_last & ~in_last);
                    if (at_last)      state_n = DONE;
                    else if (in_last) state_n = FILL;
                end
            end
            FILL: begin
                we_n = 1'b1;
                if (at_last) state_n = DONE;
            end
            DONE: begin
                launch = start;
                if (start) state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
        done_set = (state_n == DONE) && (state != DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= we_n;
            if (we_n) begin
                imem_addr  <= wr_ptr;
                imem_wdata <= wdata_n;
                if (!at_last) wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                wr_ptr   <= '0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
            end else begin
                if (err_set) err <= 1'b1;
                // Release the core on the same edge that registers the final write.
                if (done_set) begin
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/instr_loader_encoder.md
Name: instr_loader_encoder

Overview:
- Builds RV32I machine words from field-level requests and writes them sequentially into instruction memory from address 0.
- Holds the single-cycle core stalled via cpu_hold until the program is fully loaded.
- Encodes exactly the subset the core's control decoder accepts: ADD, SUB, AND, OR, XOR, SLT, ADDI, LB, SB, BEQ.
- Pads the unused tail of memory with NOP (addi x0,x0,0). It is the writer/encoder counterpart to the core's fetch/decode path.

Parameters:
- IMEM_DEPTH, 64, instruction memory depth in words (power of two, ≥2).
- ADDR_W, $clog2(IMEM_DEPTH), word-address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin load; honoured only in IDLE or DONE.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 ADDI, 7 LB, 8 SB, 9 BEQ; 10–15 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source 1.
- in_rs2  in  5  source 2.
- in_imm  in  13  immediate: I/S use [11:0]; BEQ uses [12:1], bit 0 ignored.
- in_last  in  1  final instruction of program.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- cpu_hold  out  1  1 = core held in reset/stall.
- done  out  1  program loaded.
- err  out  1  sticky: illegal kind or truncation.

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, imem_we=0, imem_addr=0, imem_wdata=0, in_ready=0, cpu_hold=1, done=0, err=0.
- All outputs are registered. in_ready = (state==LOAD), decoded from registered state.
- IDLE: wait. start → LOAD; wr_ptr=0, err cleared, cpu_hold=1.
- LOAD, accept at cycle N:
  - Cycle N+1: imem_we=1, imem_addr=wr_ptr, imem_wdata=encode(fields). wr_ptr increments.
  - Throughput: 1 word/cycle.
  - Illegal in_kind: writes NOP 0x00000013, sets err, load continues.
- LOAD exits, evaluated on the accepting cycle:
  - in_last & wr_ptr<DEPTH-1 → FILL.
  - in_last & wr_ptr==DEPTH-1 → DONE.
  - !in_last & wr_ptr==DEPTH-1 → DONE with err=1 (truncation). No further request accepted.
- FILL: each cycle emits NOP at wr_ptr (registered, visible next cycle) and increments wr_ptr. When the emitted address is DEPTH-1 → DONE.
- DONE: done=1 and cpu_hold=0 from the same cycle as the final imem_we pulse. Held until reset or start. start → LOAD: done=0, cpu_hold=1, err cleared.
- start in LOAD/FILL is ignored. in_valid outside LOAD is ignored; there is no buffering.
- Reset mid-operation returns to IDLE with reset values. Partially written memory is not cleared.
- wr_ptr never wraps. Writes above DEPTH-1 are impossible.
- Encodings (op / funct3 / funct7):
  - R-type, op 0110011: ADD 000/0000000, SUB 000/0100000, AND 111/0, OR 110/0, XOR 100/0, SLT 010/0.
  - ADDI: 0010011/000, I-type {imm[11:0],rs1,f3,rd,op}.
  - LB: 0000011/000, I-type.
  - SB: 0100011/000, {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - BEQ: 1100011/000, {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - Unused fields are forced to zero (e.g. rs2 for I-type, rd for S/B).

Decomposition:
- Package riscv_pkg:
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
  - funct3/funct7 constants.
  - instr_kind_t enum (4-bit).
  - NOP_WORD = 32'h00000013.
  - loader_state_t {IDLE, LOAD, FILL, DONE}.
- Sub-module instr_word_encoder: purely combinational; kind + fields → word[31:0] + illegal flag.
- Top holds the FSM, wr_ptr, and output registers.

Test Plan:
- Encoding: ADD x3,x1,x2 → 0x002081B3; SUB x5,x6,x7 → 0x407302B3; ADDI x1,x0,imm=0xFFF → 0xFFF00093; LB x4,0(x1) → 0x00008203; SB x2,8(x1) → 0x00208423; BEQ x1,x2,imm=0x1FFC → 0xFE208EE3.
- DEPTH=8: start, 3 back-to-back words, last on 3rd → addr 0..2 written on consecutive cycles; NOP at addr 3..7; done=1 and cpu_hold=0 in the cycle of the addr-7 write; exactly 8 imem_we pulses.
- DEPTH=8, 9 words without last → 8 writes, in_ready=0 after the 8th, err=1, done=1, 9th word never written.
- in_kind=15 at addr 2 → imem_wdata=0x00000013 at addr 2, err=1, subsequent words still written at addr 3+.
- Backpressure/ignore: in_valid toggling 1-0-1 → only valid cycles produce writes, addresses contiguous; in_valid in IDLE/DONE → no imem_we.
- Reset asserted mid-LOAD after 2 writes → next cycle IDLE, cpu_hold=1, done=0, err=0; a new start reloads from addr 0.
